// File: rtl/reduced_clock_checker_pkg.sv
// Shared constants and FSM encoding for the reduced clock checker and the debug clock divider.
package reduced_clock_checker_pkg;

    localparam int unsigned DefHighCycles = 26;
    localparam int unsigned DefLowCycles  = 25;
    localparam int unsigned DefTol        = 1;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMeasHigh = 2'd1,
        StMeasLow  = 2'd2
    } state_e;

    // Lower tolerance bound, clamped at zero so unsigned compares stay valid.
    function automatic int unsigned lower_bound(input int unsigned nominal, input int unsigned tol);
        return (nominal > tol) ? nominal - tol : 0;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus a history flop for rise/fall pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/reduced_clock_checker.sv
// Measures high/low phase lengths of a divided clock and qualifies it (lock, error, stall).
// Optional error statistics counter enabled by defining CLOCK_CHECK_STATS_EN.
module reduced_clock_checker
    import reduced_clock_checker_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES  = DefHighCycles,
    parameter int unsigned LOW_CYCLES   = DefLowCycles,
    parameter int unsigned TOL          = DefTol,
    parameter int unsigned LOCK_PERIODS = 4,
    parameter int unsigned TIMEOUT      = 200,
    parameter int unsigned CNT_W        = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_mon,
    output logic             locked,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             err,
    output logic [15:0]      err_count
);

    localparam int unsigned LockW = $clog2(LOCK_PERIODS + 1);

    localparam logic [CNT_W-1:0] HiMin    = CNT_W'(lower_bound(HIGH_CYCLES, TOL));
    localparam logic [CNT_W-1:0] HiMax    = CNT_W'(HIGH_CYCLES + TOL);
    localparam logic [CNT_W-1:0] LoMin    = CNT_W'(lower_bound(LOW_CYCLES, TOL));
    localparam logic [CNT_W-1:0] LoMax    = CNT_W'(LOW_CYCLES + TOL);
    localparam logic [CNT_W-1:0] TimeoutV = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [LockW-1:0] LockV    = LockW'(LOCK_PERIODS);

    logic             rise, fall;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic [LockW-1:0] good_cnt_q, good_cnt_inc;
    logic             timeout_hit, good_period;

    sync_edge_detect u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (clk_mon),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        cnt_inc      = cnt_q + 1'b1;
        timeout_hit  = (cnt_inc == TimeoutV);
        // cnt_q holds the low-phase length at the closing rise.
        good_period  = (high_len >= HiMin) && (high_len <= HiMax) &&
                       (cnt_q >= LoMin) && (cnt_q <= LoMax);
        good_cnt_inc = (good_cnt_q == LockV) ? good_cnt_q : good_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            good_cnt_q   <= '0;
            locked       <= 1'b0;
            period_valid <= 1'b0;
            err          <= 1'b0;
            high_len     <= '0;
            low_len      <= '0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        cnt_q   <= CntOne;
                        state_q <= StMeasHigh;
                    end
                end
                StMeasHigh: begin
                    if (fall) begin
                        high_len <= cnt_q;
                        cnt_q    <= CntOne;
                        state_q  <= StMeasLow;
                    end else if (timeout_hit) begin
                        err        <= 1'b1;
                        locked     <= 1'b0;
                        good_cnt_q <= '0;
                        cnt_q      <= '0;
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StMeasLow: begin
                    if (rise) begin
                        low_len      <= cnt_q;
                        period_valid <= 1'b1;
                        cnt_q        <= CntOne;
                        state_q      <= StMeasHigh;
                        if (good_period) begin
                            good_cnt_q <= good_cnt_inc;
                            if (good_cnt_inc == LockV) locked <= 1'b1;
                        end else begin
                            err        <= 1'b1;
                            good_cnt_q <= '0;
                            locked     <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        err        <= 1'b1;
                        locked     <= 1'b0;
                        good_cnt_q <= '0;
                        cnt_q      <= '0;
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CLOCK_CHECK_STATS_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else if (err && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_reduced_clock_checker.sv
// Self-checking bench: directed vector table, timeout/reset sequences, then random waveforms.
module tb_reduced_clock_checker;

    localparam int HI = 26;
    localparam int LO = 25;
    localparam int TL = 1;
    localparam int LOCKN = 4;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_mon = 1'b0;
    logic        locked, period_valid, err;
    logic [10:0] high_len, low_len;
    logic [15:0] err_count;

    int total = 0;
    int bad = 0;

    reduced_clock_checker u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_mon     (clk_mon),
        .locked      (locked),
        .period_valid(period_valid),
        .high_len    (high_len),
        .low_len     (low_len),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pv;
        bit er;
        int hi;
        int lo;
        bit lk;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        bit er;
        bit lk;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[19];

    // Reference model: phase-level view of the waveform
    int m_meas;   // 0 idle, 1 measuring high, 2 measuring low
    int m_level, m_len, m_hi, m_gcnt, exp_errs;
    bit m_lk, model_push;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push_exp(input bit pv, input bit er, input int h, input int l, input bit lk);
        exp_t e;
        e.pv = pv; e.er = er; e.hi = h; e.lo = l; e.lk = lk;
        exp_q.push_back(e);
        if (er) exp_errs++;
    endtask

    task automatic model_reset();
        m_meas = 0; m_level = 0; m_len = 0; m_hi = 0; m_gcnt = 0; m_lk = 0; exp_errs = 0;
    endtask

    task automatic model_eval(input int h, input int l);
        int dh, dl;
        bit good;
        dh = (h > HI) ? h - HI : HI - h;
        dl = (l > LO) ? l - LO : LO - l;
        good = (dh <= TL) && (dl <= TL);
        if (good) begin
            if (m_gcnt < LOCKN) m_gcnt++;
            if (m_gcnt == LOCKN) m_lk = 1;
        end else begin
            m_gcnt = 0;
            m_lk = 0;
        end
        if (model_push) push_exp(1'b1, !good, h, l, m_lk);
    endtask

    task automatic model_step(input int level);
        if (level != m_level) begin
            if (level == 1) begin
                if (m_meas == 2) model_eval(m_hi, m_len);
                m_meas = 1;
            end else if (m_meas == 1) begin
                m_hi = m_len;
                m_meas = 2;
            end
            m_level = level;
            m_len = 1;
        end else begin
            m_len++;
        end
        if (m_meas != 0 && m_len == TMO) begin
            m_gcnt = 0;
            m_lk = 0;
            m_meas = 0;
            if (model_push) push_exp(1'b0, 1'b1, 0, 0, 1'b0);
        end
    endtask

    task automatic drive_phase(input int level, input int n);
        for (int i = 0; i < n; i++) begin
            clk_mon = (level != 0);
            model_step(level);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int exp_err_count();
`ifdef CLOCK_CHECK_STATS_EN
        return (exp_errs > 65535) ? 65535 : exp_errs;
`else
        return 0;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_period_valid"}, period_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_high_len"}, high_len, 0);
        check({tag, "_low_len"}, low_len, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive_phase(1, tbl[i].hi);
            drive_phase(0, tbl[i].lo);
            push_exp(1'b1, tbl[i].er, tbl[i].hi, tbl[i].lo, tbl[i].lk);
        end
    endtask

    function automatic int pick(input int nominal);
        int r;
        r = $urandom_range(0, 19);
        if (r < 13) return $urandom_range(nominal - 1, nominal + 1);
        if (r < 17) return $urandom_range(1, 40);
        if (r < 18) return 205;
        return nominal;
    endfunction

    // Every period_valid or err pulse must match the next expected event
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (period_valid || err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got pv=%0d err=%0d hi=%0d lo=%0d required none",
                         period_valid, err, high_len, low_len);
            end else begin
                e = exp_q.pop_front();
                if (period_valid !== e.pv || err !== e.er || locked !== e.lk ||
                    (e.pv && (high_len !== 11'(e.hi) || low_len !== 11'(e.lo)))) begin
                    bad++;
                    $display("FAIL event: got pv=%0d err=%0d lk=%0d hi=%0d lo=%0d required pv=%0d err=%0d lk=%0d hi=%0d lo=%0d",
                             period_valid, err, locked, high_len, low_len,
                             e.pv, e.er, e.lk, e.hi, e.lo);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{26, 25, 0, 0};
        tbl[1]  = '{26, 25, 0, 0};
        tbl[2]  = '{26, 25, 0, 0};
        tbl[3]  = '{26, 25, 0, 1};
        tbl[4]  = '{29, 25, 1, 0};
        tbl[5]  = '{26, 25, 0, 0};
        tbl[6]  = '{26, 25, 0, 0};
        tbl[7]  = '{26, 25, 0, 0};
        tbl[8]  = '{26, 25, 0, 1};
        tbl[9]  = '{27, 24, 0, 1};
        tbl[10] = '{25, 26, 0, 1};
        tbl[11] = '{28, 25, 1, 0};
        tbl[12] = '{26, 27, 1, 0};
        tbl[13] = '{24, 25, 1, 0};
        tbl[14] = '{26, 25, 0, 0};
        tbl[15] = '{26, 25, 0, 0};
        tbl[16] = '{26, 25, 0, 0};
        tbl[17] = '{26, 25, 0, 0};
        tbl[18] = '{26, 25, 0, 1};

        model_reset();
        model_push = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        // Directed: lock, single bad period, tolerance edges
        drive_phase(0, 5);
        run_vectors(0, 14);

        // Stall with clk_mon held high, then restart from idle
        push_exp(1'b0, 1'b1, 0, 0, 1'b0);
        drive_phase(1, 250);
        drive_phase(0, 10);
        run_vectors(15, 18);
        drive_phase(1, 26);
        drive_phase(0, 10);
        check("directed_drained", exp_q.size(), 0);
        check("directed_locked", locked, 1);
        check("directed_err_count", err_count, exp_err_count());

        // Reset in the middle of a low phase discards the partial period
        reset_n = 1'b0;
        drive_phase(0, 1);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_values("midreset");
        drive_phase(0, 10);
        check("midreset_no_event", exp_q.size(), 0);

        // Random waveforms checked against the model
        model_push = 1;
        for (int p = 0; p < 40; p++) begin
            drive_phase(1, pick(HI));
            drive_phase(0, pick(LO));
        end
        drive_phase(1, HI);
        drive_phase(0, 12);
        check("random_drained", exp_q.size(), 0);
        check("random_locked", locked, m_lk);
        check("random_err_count", err_count, exp_err_count());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reduced_clock_checker.md
# reduced_clock_checker

Debug-path monitor that receives a divided ("reduced") clock waveform and checks its shape, sampling it as data in the fast system clock domain. It measures the high-phase and low-phase length of every period in system-clock cycles and compares each against expected values within a tolerance. It declares lock after a run of good periods and flags deviations or a stalled waveform. It sits beside the SpaceWire debug clock divider and qualifies its output before debug logic relies on it.

## Interface
- HIGH_CYCLES, 26, expected high-phase length (clk cycles)
- LOW_CYCLES, 25, expected low-phase length (clk cycles)
- TOL, 1, allowed absolute deviation per phase
- LOCK_PERIODS, 4, consecutive good periods required for lock
- TIMEOUT, 200, phase length at which the input is declared stalled
- CNT_W, 11, width of phase counters
- clk  input  1  system clock, all logic on posedge
- reset_n  input  1  synchronous, active-low reset
- clk_mon  input  1  reduced clock under test, treated as async data
- locked  output  1  waveform within spec for LOCK_PERIODS periods
- period_valid  output  1  one-cycle pulse, a period measurement completed
- high_len  output  CNT_W  last measured high-phase length
- low_len  output  CNT_W  last measured low-phase length
- err  output  1  one-cycle pulse on out-of-tolerance period or timeout
- err_count  output  16  saturating error count (see Configuration)

## Operation
- clk_mon passes a 2-flop synchronizer; a third flop holds the previous sample; rise = s & ~prev, fall = ~s & prev.
- FSM states: IDLE, MEAS_HIGH, MEAS_LOW.
- IDLE: wait for rise; on rise cnt<=1, go MEAS_HIGH. A first partial period is never evaluated.
- MEAS_HIGH: on fall, latch high_len<=cnt, cnt<=1, go MEAS_LOW; else cnt<=cnt+1.
- MEAS_LOW: on rise, latch low_len<=cnt, pulse period_valid, evaluate, cnt<=1, go MEAS_HIGH; else cnt<=cnt+1.
- Good period: |high_len−HIGH_CYCLES|<=TOL and |low_len−LOW_CYCLES|<=TOL. Compute with unsigned compares against precomputed bounds; no signed arithmetic.
- Good: good_cnt increments, saturating at LOCK_PERIODS; locked<=1 when good_cnt reaches LOCK_PERIODS.
- Bad: err pulse, good_cnt<=0, locked<=0. Measurement continues in MEAS_HIGH.
- Timeout: in MEAS_HIGH/MEAS_LOW, when cnt reaches TIMEOUT, pulse err, clear locked and good_cnt, go IDLE.
- cnt never exceeds TIMEOUT. TIMEOUT < 2^CNT_W is required.

## Timing
- Reset values: locked=0, period_valid=0, err=0, high_len=0, low_len=0, err_count=0, state IDLE, sync flops 0.
- Edge-to-detect latency: 3 clk cycles from a clk_mon transition to rise/fall.
- period_valid, updated low_len and err (bad period) assert in the same cycle, 1 cycle after rise is detected.
- locked rises in the same cycle as the LOCK_PERIODS-th good period_valid.
- Reset asserted mid-measurement returns to IDLE next cycle; the partial period is discarded.
- Glitch shorter than 1 clk is not required to be seen; a 1-cycle phase is measured as length 1.

## Configuration
- CLOCK_CHECK_STATS_EN defined: err_count increments on every err pulse and saturates at 16'hFFFF. Only reset clears it.
- Undefined: err_count tied to 0 and no counter logic is synthesized.

## Structure
- Shared package/include: FSM state encodings (IDLE=2'd0, MEAS_HIGH=2'd1, MEAS_LOW=2'd2) and the default HIGH_CYCLES/LOW_CYCLES/TOL constants shared with the divider.
- One sub-module: sync_edge_detect (2-flop synchronizer plus rise/fall outputs), reusable for other debug inputs.

## Test plan
- Drive clk_mon high 26 / low 25 continuously -> first period_valid with high_len=26, low_len=25; locked=1 at the 4th period_valid; err never asserts.
- After lock, drive one period with high 29 -> err pulse and locked=0 at that period_valid; relock after 4 further good periods.
- Boundary tolerance: high 27/low 24 -> good; high 28/low 25 -> err.
- Hold clk_mon at 1 after lock -> err pulse when cnt reaches 200; locked=0; FSM in IDLE. Restart waveform -> first rise ignored for measurement; lock after 4 good periods.
- Assert reset_n=0 mid-MEAS_LOW for 1 cycle -> all outputs at reset values next cycle; no period_valid for the interrupted period.
- With CLOCK_CHECK_STATS_EN: inject 3 bad periods -> err_count=3. Without the macro -> err_count stays 0.
